// File: rtl/rf_pkg.sv
// Shared register-file types, defaults and width helpers for decode/writeback.
package rf_pkg;

  localparam int unsigned RF_XLEN  = 32;
  localparam int unsigned RF_NREGS = 32;

  typedef logic [0:0] rf_state_t;
  localparam rf_state_t CLEAR = 1'b0;
  localparam rf_state_t RUN   = 1'b1;

  // Address width for a register count.
  function automatic int unsigned rf_aw(input int unsigned nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  // Pending-count width: one bit wider than the address.
  function automatic int unsigned rf_cw(input int unsigned nregs);
    return rf_aw(nregs) + 1;
  endfunction

endpackage

// File: rtl/rf_scoreboard_busy.sv
// Pending-write busy vector with reserve/release handshake and pending count.
module rf_scoreboard_busy
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = RF_NREGS,
  localparam int unsigned AW = rf_aw(NREGS),
  localparam int unsigned CW = rf_cw(NREGS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             wen,
  input  logic [AW-1:0]    wa,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_adr,
  output logic [NREGS-1:0] busy,
  output logic             rsv_rdy_c,
  output logic [CW-1:0]    pend_cnt
);

  logic             rel;
  logic             acc;
  logic             clr_set;
  logic [NREGS-1:0] busy_d;
  logic [CW-1:0]    cnt_d;

  // A same-cycle release of the requested register frees it for re-reservation.
  assign rsv_rdy_c = en & (!busy[rsv_adr] | (wen & (wa == rsv_adr)));

  always_comb begin
    rel     = en & wen & (wa != '0);
    acc     = en & rsv_en & rsv_rdy_c & (rsv_adr != '0);
    clr_set = rel & busy[wa];
    busy_d  = busy;
    cnt_d   = pend_cnt;
    if (rel) busy_d[wa] = 1'b0;
    if (acc) busy_d[rsv_adr] = 1'b1;
    // An accepted reserve always lands on a register that ends this cycle free.
    if (acc && !clr_set) cnt_d = pend_cnt + CW'(1);
    else if (!acc && clr_set) cnt_d = pend_cnt - CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_d;
      pend_cnt <= cnt_d;
    end
  end

  pend_cnt_matches_busy: assert property (@(posedge CLK) disable iff (RST)
    pend_cnt == CW'($countones(busy)));

endmodule

// File: rtl/rf_scoreboard.sv
// Parametrised register file with post-reset clear sweep, optional write bypass
// and per-register pending-write scoreboard.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned XLEN   = RF_XLEN,
  parameter int unsigned NREGS  = RF_NREGS,
  parameter int unsigned NRD    = 2,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW = rf_aw(NREGS),
  localparam int unsigned CW = rf_cw(NREGS)
) (
  input  logic                CLK,
  input  logic                RST,
  output logic                RF_READY,
  input  logic [NRD*AW-1:0]   RF_RADR,
  output logic [NRD*XLEN-1:0] RF_RDATA,
  output logic [NRD-1:0]      RF_RBUSY,
  input  logic                RF_WEN,
  input  logic [AW-1:0]       RF_WA,
  input  logic [XLEN-1:0]     RF_WD,
  input  logic                RF_RSV_EN,
  input  logic [AW-1:0]       RF_RSV_ADR,
  output logic                RF_RSV_RDY,
  output logic [CW-1:0]       RF_PEND_CNT
);

  rf_state_t        state_q;
  rf_state_t        state_d;
  logic [AW-1:0]    idx_q;
  logic [AW-1:0]    idx_d;
  logic             run_c;
  logic [NREGS-1:0] busy;
  logic [XLEN-1:0]  mem [NREGS];

  assign run_c    = (state_q == RUN) & !RST;
  assign RF_READY = run_c;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Sweep one register per cycle, then hand over to normal operation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == CLEAR) begin
      idx_d = idx_q + AW'(1);
      if (idx_q == AW'(NREGS - 1)) state_d = RUN;
    end
  end

  // Single write port and no reset on the array keeps it mappable to LUTRAM.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_q == CLEAR) mem[idx_q] <= '0;
      else if (RF_WEN && (RF_WA != '0)) mem[RF_WA] <= RF_WD;
    end
  end

  rf_scoreboard_busy #(.NREGS(NREGS)) u_busy (
    .CLK       (CLK),
    .RST       (RST),
    .en        (run_c),
    .wen       (RF_WEN),
    .wa        (RF_WA),
    .rsv_en    (RF_RSV_EN),
    .rsv_adr   (RF_RSV_ADR),
    .busy      (busy),
    .rsv_rdy_c (RF_RSV_RDY),
    .pend_cnt  (RF_PEND_CNT)
  );

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   a;
    logic            hit;
    logic [XLEN-1:0] d;
    logic            b;

    assign a   = RF_RADR[p*AW +: AW];
    assign hit = BYPASS & RF_WEN & (RF_WA == a);

    always_comb begin
      d = '0;
      b = 1'b0;
      if (run_c && (a != '0)) begin
        if (hit) begin
          d = RF_WD;
        end else begin
          d = mem[a];
          b = busy[a];
        end
      end
    end

    assign RF_RDATA[p*XLEN +: XLEN] = d;
    assign RF_RBUSY[p]              = b;
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Scoreboard bench driving a bypassed and a non-bypassed instance in lockstep.
module tb_rf_scoreboard;
  import rf_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NR   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRD  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, wen, rsv_en;
  logic [AW-1:0]       wa, rsv_adr;
  logic [XLEN-1:0]     wd;
  logic [NRD*AW-1:0]   radr;

  logic                b_ready, n_ready, b_rdy, n_rdy;
  logic [NRD*XLEN-1:0] b_rdata, n_rdata;
  logic [NRD-1:0]      b_rbusy, n_rbusy;
  logic [AW:0]         b_cnt, n_cnt;

  rf_scoreboard #(.XLEN(XLEN), .NREGS(NR), .NRD(NRD), .BYPASS(1'b1)) dut_b (
    .CLK(clk), .RST(rst), .RF_READY(b_ready), .RF_RADR(radr), .RF_RDATA(b_rdata),
    .RF_RBUSY(b_rbusy), .RF_WEN(wen), .RF_WA(wa), .RF_WD(wd), .RF_RSV_EN(rsv_en),
    .RF_RSV_ADR(rsv_adr), .RF_RSV_RDY(b_rdy), .RF_PEND_CNT(b_cnt));

  rf_scoreboard #(.XLEN(XLEN), .NREGS(NR), .NRD(NRD), .BYPASS(1'b0)) dut_n (
    .CLK(clk), .RST(rst), .RF_READY(n_ready), .RF_RADR(radr), .RF_RDATA(n_rdata),
    .RF_RBUSY(n_rbusy), .RF_WEN(wen), .RF_WA(wa), .RF_WD(wd), .RF_RSV_EN(rsv_en),
    .RF_RSV_ADR(rsv_adr), .RF_RSV_RDY(n_rdy), .RF_PEND_CNT(n_cnt));

  typedef struct {
    logic            ready;
    logic            rdy;
    logic [AW:0]     cnt;
    logic [XLEN-1:0] bd [NRD];
    logic [XLEN-1:0] nd [NRD];
    logic            bb [NRD];
    logic            nb [NRD];
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state (register contents after the last posedge).
  bit              m_run;
  int              m_idx;
  logic [XLEN-1:0] m_mem [NR];
  bit              m_busy [NR];
  int              m_cnt;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic void mread(input int a, input bit byp, output logic [XLEN-1:0] d,
                                output logic b);
    d = '0;
    b = 1'b0;
    if (m_run && !rst && a != 0) begin
      if (byp && wen && int'(wa) == a) d = wd;
      else begin
        d = m_mem[a];
        b = m_busy[a];
      end
    end
  endfunction

  task automatic step();
    exp_t e, o;
    bit   rdy, rel, acc;
    int   a;
    rdy     = m_run && !rst && (rsv_adr == 0 || !m_busy[rsv_adr] || (wen && wa == rsv_adr));
    e.ready = m_run && !rst;
    e.rdy   = rdy;
    e.cnt   = (AW+1)'(m_cnt);
    for (int p = 0; p < NRD; p++) begin
      a = int'(radr[p*AW +: AW]);
      mread(a, 1'b1, e.bd[p], e.bb[p]);
      mread(a, 1'b0, e.nd[p], e.nb[p]);
    end
    q.push_back(e);
    @(negedge clk);
    o = q.pop_front();
    chk("ready_b", 64'(b_ready), 64'(o.ready));
    chk("ready_n", 64'(n_ready), 64'(o.ready));
    chk("rsv_rdy_b", 64'(b_rdy), 64'(o.rdy));
    chk("rsv_rdy_n", 64'(n_rdy), 64'(o.rdy));
    chk("cnt_b", 64'(b_cnt), 64'(o.cnt));
    chk("cnt_n", 64'(n_cnt), 64'(o.cnt));
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("rdata_b%0d", p), 64'(b_rdata[p*XLEN +: XLEN]), 64'(o.bd[p]));
      chk($sformatf("rdata_n%0d", p), 64'(n_rdata[p*XLEN +: XLEN]), 64'(o.nd[p]));
      chk($sformatf("rbusy_b%0d", p), 64'(b_rbusy[p]), 64'(o.bb[p]));
      chk($sformatf("rbusy_n%0d", p), 64'(n_rbusy[p]), 64'(o.nb[p]));
    end
    // Advance the model exactly as the posedge will.
    if (rst) begin
      m_run = 0; m_idx = 0; m_cnt = 0;
      for (int i = 0; i < NR; i++) m_busy[i] = 0;
    end else if (!m_run) begin
      m_mem[m_idx] = '0;
      if (m_idx == NR - 1) begin m_run = 1; m_idx = 0; end
      else m_idx++;
    end else begin
      rel = wen && wa != 0;
      acc = rsv_en && rdy && rsv_adr != 0;
      if (rel) begin
        m_mem[wa] = wd;
        if (m_busy[wa]) m_cnt--;
        m_busy[wa] = 0;
      end
      if (acc) begin
        if (!m_busy[rsv_adr]) m_cnt++;
        m_busy[rsv_adr] = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit r, input bit we, input int a, input logic [XLEN-1:0] d,
                     input bit re, input int ra, input int p0, input int p1);
    rst = r; wen = we; wa = AW'(a); wd = d; rsv_en = re; rsv_adr = AW'(ra);
    radr = {AW'(p1), AW'(p0)};
    step();
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (b_ready !== 1'b1 && n < 100) begin
      cyc(0, 0, 0, 0, 0, 0, n % NR, (NR - 1 - n) % NR);
      n++;
    end
    chk(tag, 64'(n), 64'(NR));
  endtask

  initial begin
    int ord [NR-1];
    int j, t;
    rst = 1; wen = 0; wa = '0; wd = '0; rsv_en = 0; rsv_adr = '0; radr = '0;
    for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
    m_run = 0; m_idx = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset pulse and full sweep, then every register reads zero.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    wait_ready("sweep_len");
    for (int i = 0; i < NR; i++) cyc(0, 0, 0, 0, 0, 0, i, NR - 1 - i);

    // Restart at sweep index 10 wipes earlier writes.
    cyc(0, 1, 3, 32'h55, 0, 0, 3, 0);
    cyc(1, 0, 0, 0, 0, 0, 3, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0, 3, i);
    cyc(1, 0, 0, 0, 0, 0, 3, 0);
    wait_ready("restart_len");
    cyc(0, 0, 0, 0, 0, 0, 3, 10);
    chk("x3_cleared", 64'(b_rdata[XLEN-1:0]), 64'h0);

    // Bypass vs. registered visibility.
    cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
    cyc(0, 0, 0, 0, 0, 0, 5, 0);

    // Reserve, blocked re-reserve, release.
    cyc(0, 0, 0, 0, 1, 7, 7, 0);
    cyc(0, 0, 0, 0, 1, 7, 7, 7);
    cyc(0, 1, 7, 32'h12, 0, 0, 7, 0);
    cyc(0, 0, 0, 0, 0, 0, 7, 7);

    // Write and re-reserve the same busy register in one cycle.
    cyc(0, 0, 0, 0, 1, 9, 9, 0);
    cyc(0, 1, 9, 32'hA5A5_0009, 1, 9, 9, 9);
    cyc(0, 0, 0, 0, 0, 0, 9, 9);
    chk("x9_busy", 64'(n_rbusy[0]), 64'h1);

    // Register zero ignores writes and reserves.
    cyc(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 9);
    cyc(0, 1, 9, 32'h99, 0, 0, 9, 0);

    // Reserve every register, then release in random order.
    for (int i = 1; i < NR; i++) cyc(0, 0, 0, 0, 1, i, i, i - 1);
    cyc(0, 0, 0, 0, 0, 0, 31, 1);
    chk("cnt_full", 64'(b_cnt), 64'(NR - 1));
    for (int i = 0; i < NR - 1; i++) ord[i] = i + 1;
    for (int i = NR - 2; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    for (int i = 0; i < NR - 1; i++)
      cyc(0, 1, ord[i], $urandom, (i % 3) == 0, ord[(i + 5) % (NR - 1)], ord[i],
          ord[(i + 1) % (NR - 1)]);
    for (int i = 0; i < NR; i++) cyc(0, 0, 0, 0, 0, 0, i, (i + 7) % NR);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Parametrised successor to the single-cycle register file, for the pipelined/multi-cycle OTTER core.
- Adds the following to the existing feature set:
  - configurable XLEN, register count and read-port count;
  - optional write-to-read bypass;
  - a per-register pending-write scoreboard with a reserve/release handshake;
  - a sequential post-reset clear sweep, so the storage array can remain LUTRAM.
- Sits between decode (read/reserve) and writeback (write/release).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, ≥4. AW = $clog2(NREGS) is derived.
- NRD, 2, number of asynchronous read ports, 1..4.
- BYPASS, 1, 1 = same-cycle writeback data and release are visible on read ports.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- RF_READY  out  1  high once the clear sweep has finished.
- RF_RADR  in  NRD*AW  packed read addresses; port p = bits [p*AW +: AW].
- RF_RDATA  out  NRD*XLEN  packed read data.
- RF_RBUSY  out  NRD  pending-write flag of each read address.
- RF_WEN  in  1  writeback strobe.
- RF_WA  in  AW  writeback address.
- RF_WD  in  XLEN  writeback data.
- RF_RSV_EN  in  1  reserve request; marks RF_RSV_ADR pending.
- RF_RSV_ADR  in  AW  register to reserve.
- RF_RSV_RDY  out  1  reservation can be accepted this cycle (combinational).
- RF_PEND_CNT  out  AW+1  number of registers currently reserved.

Behaviour:
- Reset
  - While RST = 1: state ← CLEAR, sweep index ← 0, all busy bits ← 0, RF_PEND_CNT ← 0.
  - During CLEAR and reset, all outputs read as: RF_READY = 0, RF_RDATA = 0, RF_RBUSY = 0, RF_RSV_RDY = 0.
- FSM
  - CLEAR: one register is written with 0 per cycle (index 0..NREGS-1).
  - CLEAR → RUN after index NREGS-1 is written, so NREGS cycles after RST falls.
  - RUN holds until RST.
  - RST asserted mid-sweep or in RUN restarts the sweep from index 0.
  - In CLEAR, RF_WEN and RF_RSV_EN are ignored.
- Reads
  - Combinational; address 0 always returns 0 and busy = 0.
  - With BYPASS = 1 and RF_WEN & RF_WA == addr ≠ 0: RF_RDATA = RF_WD and RF_RBUSY = 0.
  - With BYPASS = 0: stored values are read; a write becomes visible in the cycle after the posedge.
- Write (RUN)
  - RF_WEN with RF_WA ≠ 0 stores RF_WD at posedge and clears busy[RF_WA].
  - Writing a non-busy register is legal: data is stored, busy is unchanged at 0.
  - Writes to address 0 are dropped.
- Reserve handshake (RUN)
  - RF_RSV_RDY = !busy[RF_RSV_ADR] | (RF_WEN & RF_WA == RF_RSV_ADR).
  - Accept = RF_RSV_EN & RF_RSV_RDY; on accept, busy[RF_RSV_ADR] ← 1 at posedge.
  - Requester holds RF_RSV_EN/RF_RSV_ADR until RF_RSV_RDY; no state changes while it is low.
  - Reserve of address 0 is always ready and has no effect.
- Simultaneous write and reserve
  - Same address: release then re-reserve, so busy ends at 1 and the data is written.
  - Different addresses: both take effect.
- RF_PEND_CNT, updated at posedge
  - +1 on an accepted nonzero reserve of a non-busy register.
  - −1 on a write that clears a set busy bit.
  - Both in the same cycle: unchanged.
  - Never wraps: range 0..NREGS-1 by construction.
  - Assertion: the count equals the popcount of the busy bits.
- All read ports are independent; duplicate addresses across ports return identical data.

Decomposition:
- Package rf_pkg holds:
  - typedef rf_state_t {CLEAR, RUN};
  - function clog2-based width helpers;
  - localparam defaults for XLEN and NREGS, shared with decode/writeback.
- Sub-module rf_scoreboard_busy contains the busy vector, the reserve/release logic and RF_PEND_CNT.
- Storage, the sweep FSM and the read/bypass muxes stay in the top module.

Test Plan:
1. Pulse RST 1 cycle, then idle → RF_READY = 0 for exactly 32 cycles, then 1. Every register reads 0. RST asserted again at sweep index 10 → RF_READY stays 0 until 32 cycles after RST falls.
2. RUN, BYPASS = 1: RF_WEN = 1, RF_WA = 5, RF_WD = 0xDEADBEEF with RF_RADR port0 = 5 → RF_RDATA port0 = 0xDEADBEEF in the same cycle. Same sequence with BYPASS = 0 → old value 0 in the same cycle, 0xDEADBEEF next cycle.
3. Reserve x7 → RF_RBUSY = 1 on reading x7, RF_PEND_CNT = 1. A second reserve of x7 gives RF_RSV_RDY = 0 and no change. Write x7 = 0x12 → busy 0, RF_PEND_CNT = 0.
4. In the same cycle, write x9 (busy) and reserve x9 → RF_RSV_RDY = 1; next cycle busy[9] = 1, data = written value, RF_PEND_CNT unchanged.
5. Write x0 = 0xFFFFFFFF and reserve x0 → x0 reads 0, RF_RBUSY = 0, RF_PEND_CNT unchanged.
6. Reserve x1..x31 one per cycle → RF_PEND_CNT = 31. Release all in random order → 0. Popcount assertion holds throughout.
